// File: rtl/uart_tx_fifo_if.sv
// Word-input handshake between a producer and uart_tx_fifo.
//   i_data  : word to transmit (producer -> FIFO)
//   i_valid : i_data is valid this cycle (producer -> FIFO)
//   o_ready : FIFO can accept a word (FIFO -> producer)
// A word transfers on any cycle where i_valid and o_ready are both high.
interface uart_tx_fifo_if #(
  parameter int unsigned NB_DATA = 8
) ();
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input word FIFO.
// Words pushed through the handshake interface are queued and sent LSB first as
// start / data / optional parity / stop frames, back-to-back while words remain.
// Ports:
//   i_clk        : single clock, all logic on its rising edge
//   i_reset      : synchronous active-high reset
//   bus          : word handshake (i_data, i_valid in; o_ready out)
//   o_data       : registered serial TX line, idle high
//   o_busy       : high whenever a frame is in progress
//   o_fifo_count : words currently held in the FIFO
module uart_tx_fifo #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned F_CLOCK    = 25000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned NB_STOP    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  uart_tx_fifo_if.slave               bus,
  output logic                        o_data,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int unsigned DIV = F_CLOCK / (BAUD_RATE * 16);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  localparam logic [TW-1:0] DivLast  = TW'(DIV - 1);
  localparam logic [4:0]    BitLast  = 5'd15;
  localparam logic [4:0]    StopLast = 5'(NB_STOP * 16 - 1);
  localparam logic [3:0]    DataLast = 4'(NB_DATA - 1);
  localparam logic          HasPar   = (PARITY != 0);
  localparam logic          ParOdd   = (PARITY == 2);

  if (DIV < 1) begin : g_div_check
    $error("uart_tx_fifo: F_CLOCK / (BAUD_RATE * 16) must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // 16x oversample tick
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == DivLast);

  always_ff @(posedge i_clk) begin
    if (i_reset)   tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // Input FIFO; pointers wrap naturally since the depth is a power of two
  logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               ready, push, pop, empty;
  logic [NB_DATA-1:0] head;

  assign ready       = (count_q < CW'(FIFO_DEPTH));
  assign bus.o_ready = ready;
  assign push        = bus.i_valid & ready;
  assign empty       = (count_q == '0);
  assign head        = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Frame sequencer
  state_e             state_q, state_d;
  logic [4:0]         sub_q, sub_d;     // ticks elapsed within the current bit
  logic [3:0]         bit_q, bit_d;     // data bit index
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               data_q, line_d;

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StStart;
            sub_d   = '0;
            shreg_d = head;
            par_d   = (^head) ^ ParOdd;
          end
        end
        StStart: begin
          if (sub_q == BitLast) begin
            sub_d   = '0;
            bit_d   = '0;
            state_d = StData;
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        StData: begin
          if (sub_q == BitLast) begin
            sub_d   = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == DataLast) state_d = HasPar ? StParity : StStop;
            else                   bit_d   = bit_q + 4'd1;
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        StParity: begin
          if (sub_q == BitLast) begin
            sub_d   = '0;
            state_d = StStop;
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        StStop: begin
          if (sub_q == StopLast) begin
            sub_d = '0;
            // Chain straight into the next frame when a word is waiting
            if (!empty) begin
              pop     = 1'b1;
              state_d = StStart;
              shreg_d = head;
              par_d   = (^head) ^ ParOdd;
            end else begin
              state_d = StIdle;
            end
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line level is derived from the next state so the registered pin lines up
  // with the state register.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      StStart:  line_d = 1'b0;
      StData:   line_d = shreg_d[0];
      StParity: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      sub_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= line_d;
    end
  end

  assign o_data       = data_q;
  assign o_busy       = (state_q != StIdle);
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. Four instances share clock and reset:
//   0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, all at 160 clocks per bit.
// Stimulus queues hand-computed line frames; per-instance monitors decode the
// TX line and compare every bit slot, the inter-frame gap and the busy flag.
module tb_uart_tx_fifo;

  localparam int BIT_CLK = 160;
  localparam int unsigned PAR_TAB  [4] = '{0, 1, 2, 0};
  localparam int unsigned STOP_TAB [4] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [19:0] bits;  // line level per slot, slot 0 = start bit
    logic [4:0]  len;
    logic        b2b;   // must start on the cycle the previous frame ends
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid_r = '0;
  logic [7:0] data_r [4];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [19:0] bits, input int len, input logic b2b);
    frame_t f;
    f.bits = bits;
    f.len  = 5'(len);
    f.b2b  = b2b;
    return f;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo_if #(.NB_DATA(8)) bus ();
    logic       line, busy;
    logic [2:0] count;
    frame_t     exp_q [$];

    assign bus.i_valid = valid_r[g];
    assign bus.i_data  = data_r[g];

    uart_tx_fifo #(
      .NB_DATA   (8),
      .F_CLOCK   (1600000),
      .BAUD_RATE (10000),
      .PARITY    (PAR_TAB[g]),
      .NB_STOP   (STOP_TAB[g]),
      .FIFO_DEPTH(4)
    ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .bus         (bus),
      .o_data      (line),
      .o_busy      (busy),
      .o_fifo_count(count)
    );

    initial begin : mon
      frame_t f;
      bit     pending, expect_b2b, aborted, first;
      int     bad;
      pending = 0;
      expect_b2b = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pending = 0;
          continue;
        end
        if (pending) begin
          pending = 0;
          if (expect_b2b) begin
            check($sformatf("dut%0d gap before next frame", g), line, 0);
          end else begin
            check($sformatf("dut%0d line after frame", g), line, 1);
            check($sformatf("dut%0d busy after frame", g), busy, 0);
          end
        end
        if (line === 1'b0) begin
          if (exp_q.size() == 0) begin
            check($sformatf("dut%0d unexpected frame", g), 1, 0);
            for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
          end else begin
            f = exp_q.pop_front();
            aborted = 0;
            first = 1;
            for (int s = 0; s < int'(f.len) && !aborted; s++) begin
              bad = 0;
              for (int k = 0; k < BIT_CLK && !aborted; k++) begin
                if (!first) @(negedge clk);
                first = 0;
                if (rst) aborted = 1;
                else if (line !== f.bits[s] || busy !== 1'b1) bad++;
              end
              if (!aborted) check($sformatf("dut%0d slot%0d bad samples", g, s), bad, 0);
            end
            if (!aborted) begin
              pending = 1;
              expect_b2b = (exp_q.size() > 0) && exp_q[0].b2b;
            end
          end
        end
      end
    end
  end

  task automatic sb_push(input int idx, input frame_t f);
    case (idx)
      0: g_dut[0].exp_q.push_back(f);
      1: g_dut[1].exp_q.push_back(f);
      2: g_dut[2].exp_q.push_back(f);
      default: g_dut[3].exp_q.push_back(f);
    endcase
  endtask

  // Called at posedge+1; the word is sampled at the next rising edge.
  task automatic push(input int idx, input logic [7:0] w);
    valid_r[idx] = 1'b1;
    data_r[idx]  = w;
    @(posedge clk);
    #1;
    valid_r[idx] = 1'b0;
  endtask

  task automatic wait_busy0(output bit seen);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (g_dut[0].busy) seen = 1;
    end
    check("dut0 busy rise", seen, 1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (g_dut[0].exp_q.size() == 0 && g_dut[1].exp_q.size() == 0 &&
          g_dut[2].exp_q.size() == 0 && g_dut[3].exp_q.size() == 0 &&
          !g_dut[0].busy && !g_dut[1].busy && !g_dut[2].busy && !g_dut[3].busy)
        done = 1;
    end
    check("drain", done, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] fw [5];
    bit seen;
    for (int i = 0; i < 4; i++) data_r[i] = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ready during reset", g_dut[0].bus.o_ready, 1);
    check("line during reset", g_dut[0].line, 1);
    check("busy during reset", g_dut[0].busy, 0);
    check("count during reset", g_dut[0].count, 0);
    rst = 1'b0;

    // Single frames: 8N1 0xA5, 8E1 0x07, 8O1 0x07, 8N2 0x00
    sb_push(0, mk({1'b1, 8'hA5, 1'b0}, 10, 0));
    push(0, 8'hA5);
    check("count after first push", g_dut[0].count, 1);
    sb_push(1, mk({1'b1, 1'b1, 8'h07, 1'b0}, 11, 0));
    push(1, 8'h07);
    sb_push(2, mk({1'b1, 1'b0, 8'h07, 1'b0}, 11, 0));
    push(2, 8'h07);
    sb_push(3, mk({1'b1, 1'b1, 8'h00, 1'b0}, 11, 0));
    push(3, 8'h00);
    drain(3000);

    // Full FIFO: reset aligns the tick so no pop lands during the five pushes
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33; fw[3] = 8'h44; fw[4] = 8'h55;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb_push(0, mk({1'b1, fw[i], 1'b0}, 10, i != 0));
    for (int i = 0; i < 5; i++) begin
      if (i == 3) check("ready before 4th push", g_dut[0].bus.o_ready, 1);
      push(0, fw[i]);
      if (i == 3) begin
        check("ready when full", g_dut[0].bus.o_ready, 0);
        check("count when full", g_dut[0].count, 4);
      end
    end
    check("count after dropped push", g_dut[0].count, 4);
    drain(8000);

    // Push on the exact cycle the FIFO pops at the end of a frame
    sb_push(0, mk({1'b1, 8'h3C, 1'b0}, 10, 0));
    push(0, 8'h3C);
    wait_busy0(seen);
    sb_push(0, mk({1'b1, 8'hC3, 1'b0}, 10, 1));
    push(0, 8'hC3);
    repeat (1598) @(posedge clk);
    #1;
    check("count before push-pop", g_dut[0].count, 1);
    sb_push(0, mk({1'b1, 8'h81, 1'b0}, 10, 1));
    push(0, 8'h81);
    check("count after push-pop", g_dut[0].count, 1);
    check("busy across push-pop", g_dut[0].busy, 1);
    drain(6000);

    // Reset during the 4th data bit, with a second word still queued
    sb_push(0, mk({1'b1, 8'h96, 1'b0}, 10, 0));
    push(0, 8'h96);
    wait_busy0(seen);
    push(0, 8'h69);
    repeat (718) @(posedge clk);
    #1;
    check("count before abort", g_dut[0].count, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("line after abort", g_dut[0].line, 1);
    check("busy after abort", g_dut[0].busy, 0);
    check("count after abort", g_dut[0].count, 0);
    check("ready after abort", g_dut[0].bus.o_ready, 1);
    rst = 1'b0;
    sb_push(0, mk({1'b1, 8'hF0, 1'b0}, 10, 0));
    push(0, 8'hF0);
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
